// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width,
// default reset PC / PC increment, FSM state encoding and PC mux select.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned     DEFAULT_PC_STEP  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register with its next-PC mux: hold, advance by PC_STEP
// (32-bit modulo, so the top word wraps to zero) or load a redirect target.
module if_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         pc_sel_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next-PC selection.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pc_d = pc_q;
        case (pc_sel_i)
            PC_INC:    pc_d = pc_q + STEP;
            PC_TARGET: pc_d = target_i;
            default:   pc_d = pc_q;
        endcase
    end

    // PC state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking (<=) so all flops update together at the edge.
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: a three-state Moore FSM issues one memory read
// per instruction, registers the returned word, and hands it downstream
// with a valid/ready handshake. Branch redirects are honoured in every
// state; a redirect that arrives while a read is outstanding is remembered
// so the stale response can be thrown away when it finally returns.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] fetch_count
);

    state_e          state_q, state_d;
    logic            pending_q, pending_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] count_q, count_d;

    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] pc;

    if_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .pc_sel_i (pc_sel),
        .target_i (pc_target),
        .pc_o     (pc)
    );

    // Next-state, redirect tracking and PC-mux control.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        target_d  = target_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        count_d   = count_q;
        pc_sel    = PC_HOLD;
        pc_target = branch_target;

        case (state_q)
            S_IDLE: begin
                // A stray ack here is ignored; only a redirect matters.
                state_d = S_REQ;
                if (branch_taken) pc_sel = PC_TARGET;
            end
            S_REQ: begin
                if (imem_ack) begin
                    pending_d = 1'b0;
                    if (branch_taken) begin
                        // Redirect in the ack cycle is the newest target.
                        pc_sel = PC_TARGET;
                    end else if (pending_q) begin
                        pc_sel    = PC_TARGET;
                        pc_target = target_q;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc;
                        state_d  = S_VALID;
                    end
                end else if (branch_taken) begin
                    // Keep the read alive on the old address; remember the
                    // latest target so the last redirect wins.
                    pending_d = 1'b1;
                    target_d  = branch_target;
                end
            end
            S_VALID: begin
                if (branch_taken) begin
                    pc_sel  = PC_TARGET;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    pc_sel  = PC_INC;
                    count_d = count_q + 32'd1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, redirect tracking and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            target_q  <= RESET_PC;
            instr_q   <= '0;
            pc_out_q  <= RESET_PC;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            count_q   <= count_d;
        end
    end

    // Moore outputs: decoded from state or driven straight from registers.
    assign imem_req    = (state_q == S_REQ);
    assign instr_valid = (state_q == S_VALID);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed stimulus pushes expected request addresses
// and expected deliveries into queues; a negedge monitor pops and compares
// whenever the DUT starts a request or completes a transfer.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, instr_valid, instr_ready, branch_taken;
    logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc_out, fetch_count;

    logic        imem_req_w, imem_ack_w, instr_valid_w, instr_ready_w, branch_taken_w;
    logic [31:0] imem_addr_w, imem_rdata_w, branch_target_w, instr_w, pc_out_w, fetch_count_w;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } deliv_t;

    logic [31:0] exp_addr_q[$];
    deliv_t      exp_deliv_q[$];

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .branch_taken(branch_taken_w), .branch_target(branch_target_w),
        .instr(instr_w), .pc_out(pc_out_w), .instr_valid(instr_valid_w),
        .instr_ready(instr_ready_w), .fetch_count(fetch_count_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no imem_req within 20 cycles", name);
        end
    endtask

    // Ack lat cycles after the current one, returning mem_word(addr).
    task automatic serve(input logic [31:0] addr, input int lat);
        repeat (lat) tick();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(addr);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    // One normal fetch at addr with ack two cycles after the request.
    task automatic fetch_one(input logic [31:0] addr);
        deliv_t d;
        wait_req("fetch_req");
        d.instr = mem_word(addr);
        d.pc    = addr;
        exp_deliv_q.push_back(d);
        serve(addr, 2);
        exp_addr_q.push_back(addr + 32'd4);
        check_bit("valid_after_ack", instr_valid, 1'b1);
    endtask

    // Monitor: compare each new request address and each transfer.
    logic last_req = 1'b0;
    logic last_ack = 1'b0;
    always @(negedge clk) begin
        deliv_t d;
        if (rst === 1'b0) begin
            if (imem_req && (!last_req || last_ack)) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_addr: unexpected request at %h", imem_addr);
                end else begin
                    check("sb_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (instr_valid && instr_ready && !branch_taken) begin
                if (exp_deliv_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_deliv: unexpected transfer instr=%h pc=%h", instr, pc_out);
                end else begin
                    d = exp_deliv_q.pop_front();
                    check("sb_instr", instr, d.instr);
                    check("sb_pc", pc_out, d.pc);
                end
            end
        end
        last_req = imem_req;
        last_ack = imem_ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        imem_ack = 1'b0;  imem_rdata = '0;
        branch_taken = 1'b0; branch_target = '0; instr_ready = 1'b0;
        imem_ack_w = 1'b0; imem_rdata_w = '0;
        branch_taken_w = 1'b0; branch_target_w = '0; instr_ready_w = 1'b1;
        #2 rst = 1'b1;
        repeat (2) tick();

        // Reset values
        check_bit("rst_req", imem_req, 1'b0);
        check_bit("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_addr_w", imem_addr_w, 32'hFFFF_FFFC);
        check("rst_pc_out_w", pc_out_w, 32'hFFFF_FFFC);

        // Three back-to-back fetches, ready tied high
        instr_ready = 1'b1;
        exp_addr_q.push_back(32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) fetch_one(32'(i * 4));
        tick();
        check("seq_count", fetch_count, 32'd3);

        // Downstream stall for five cycles at addr 12
        instr_ready = 1'b0;
        serve(32'd12, 2);
        for (int k = 0; k < 5; k++) begin
            check_bit("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, mem_word(32'd12));
            check("stall_pc_out", pc_out, 32'd12);
            check_bit("stall_req", imem_req, 1'b0);
            check("stall_addr", imem_addr, 32'd12);
            check("stall_count", fetch_count, 32'd3);
            tick();
        end
        begin
            deliv_t d;
            d.instr = mem_word(32'd12);
            d.pc    = 32'd12;
            exp_deliv_q.push_back(d);
        end
        exp_addr_q.push_back(32'd16);
        instr_ready = 1'b1;
        tick();
        check("stall_count_after", fetch_count, 32'd4);
        tick();

        // Reset in the middle of a request, with ack during reset and idle
        check_bit("mid_req_before", imem_req, 1'b1);
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check_bit("mid_rst_req", imem_req, 1'b0);
        check_bit("mid_rst_valid", instr_valid, 1'b0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_pc_out", pc_out, 32'h0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_count", fetch_count, 32'h0);
        tick();
        tick();
        check_bit("mid_rst_hold_valid", instr_valid, 1'b0);
        check("mid_rst_hold_count", fetch_count, 32'h0);
        rst = 1'b0;
        exp_addr_q.push_back(32'h0);
        tick();
        imem_ack = 1'b0;
        imem_rdata = '0;
        check_bit("post_rst_valid", instr_valid, 1'b0);
        check("post_rst_addr", imem_addr, 32'h0);

        // Two redirects during an outstanding read at addr 8; last wins
        fetch_one(32'h0);
        fetch_one(32'h4);
        tick();
        check("br_addr_before", imem_addr, 32'h8);
        branch_taken = 1'b1;
        branch_target = 32'h80;
        tick();
        branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        check("br_addr_hold", imem_addr, 32'h8);
        check_bit("br_req_hold", imem_req, 1'b1);
        tick();
        tick();
        imem_ack = 1'b1;
        imem_rdata = mem_word(32'h8);
        exp_addr_q.push_back(32'h100);
        tick();
        imem_ack = 1'b0;
        imem_rdata = '0;
        check_bit("br_discard_valid", instr_valid, 1'b0);
        check("br_new_addr", imem_addr, 32'h100);
        check("br_count", fetch_count, 32'd2);

        // Redirect and ready in the same S_VALID cycle: redirect wins
        serve(32'h100, 2);
        check_bit("vbr_valid", instr_valid, 1'b1);
        check("vbr_instr", instr, mem_word(32'h100));
        check("vbr_pc_out", pc_out, 32'h100);
        branch_taken = 1'b1;
        branch_target = 32'h40;
        exp_addr_q.push_back(32'h40);
        tick();
        branch_taken = 1'b0;
        check_bit("vbr_dropped", instr_valid, 1'b0);
        check("vbr_count", fetch_count, 32'd2);
        check("vbr_addr", imem_addr, 32'h40);
        fetch_one(32'h40);
        tick();
        check("vbr_count_after", fetch_count, 32'd3);

        // PC wrap on the instance reset to 32'hFFFF_FFFC
        check_bit("wrap_req", imem_req_w, 1'b1);
        check("wrap_addr_before", imem_addr_w, 32'hFFFF_FFFC);
        imem_ack_w = 1'b1;
        imem_rdata_w = 32'h1234_5678;
        tick();
        imem_ack_w = 1'b0;
        imem_rdata_w = '0;
        check_bit("wrap_valid", instr_valid_w, 1'b1);
        check("wrap_instr", instr_w, 32'h1234_5678);
        check("wrap_pc_out", pc_out_w, 32'hFFFF_FFFC);
        tick();
        check_bit("wrap_valid_after", instr_valid_w, 1'b0);
        check("wrap_addr_after", imem_addr_w, 32'h0);
        check("wrap_count", fetch_count_w, 32'd1);
        tick();

        check("sb_addr_drained", 32'(exp_addr_q.size()), 32'd0);
        check("sb_deliv_drained", 32'(exp_deliv_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, is the PC increment per accepted instruction.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  read address, equal to current PC.
REQ-007 imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 branch_taken  input  1  redirect request, one-cycle pulse.
REQ-010 branch_target  input  32  redirect PC, sampled when branch_taken=1.
REQ-011 instr  output  32  registered instruction to the downstream latch stage.
REQ-012 pc_out  output  32  PC of the word on instr.
REQ-013 instr_valid  output  1  instr/pc_out hold a deliverable instruction.
REQ-014 instr_ready  input  1  downstream accepts instr when instr_valid=1.
REQ-015 fetch_count  output  32  number of instructions accepted since reset.

Function
REQ-016 FSM states SHALL be S_IDLE, S_REQ, S_VALID; all outputs are registered or decoded from state only (Moore).
REQ-017 S_IDLE: imem_req=0, instr_valid=0; next state S_REQ unconditionally.
REQ-018 S_REQ: imem_req=1, imem_addr=pc; req held high until imem_ack=1.
REQ-019 S_REQ with imem_ack=1 and no redirect pending: capture instr<=imem_rdata, pc_out<=pc, go S_VALID; instr_valid=1 in the next cycle (1-cycle ack-to-valid latency).
REQ-020 S_VALID: instr_valid=1, imem_req=0; instr and pc_out stable until transfer.
REQ-021 S_VALID with instr_ready=1 and branch_taken=0: pc<=pc+PC_STEP, fetch_count<=fetch_count+1, go S_REQ.
REQ-022 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0; fetch_count wraps likewise.
REQ-023 branch_taken in S_REQ without imem_ack: set redirect_pending, latch target; req stays high on the old address.
REQ-024 imem_ack while redirect_pending (or with branch_taken in the same cycle): discard imem_rdata, pc<=latched/current target, clear pending, remain S_REQ with new imem_addr next cycle.
REQ-025 branch_taken in S_VALID: drop the held instruction, pc<=branch_target, go S_REQ; redirect wins over instr_ready, fetch_count not incremented.
REQ-026 branch_taken in S_IDLE: pc<=branch_target; first request uses the target.
REQ-027 Two redirects before ack: the last branch_target wins.

Reset
REQ-028 rst=1 SHALL immediately force S_IDLE, pc=RESET_PC, pc_out=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_count=0, redirect_pending=0.
REQ-029 rst asserted mid-request SHALL abandon the transaction; any imem_ack arriving while in reset or in S_IDLE SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold the state encoding, RESET_PC and PC_STEP defaults, and the 32-bit word width constant.
REQ-031 PC register with next-PC mux (hold / +PC_STEP / target) SHALL be a sub-module if_pc_reg; FSM, redirect tracking and output registers stay in if_stage.

Verification
REQ-032 Reset release, memory acks 2 cycles after each req, ready tied 1 -> imem_addr 0,4,8; instr_valid one cycle after each ack; fetch_count=3 after third transfer.
REQ-033 instr_valid=1, ready held 0 for 5 cycles -> instr, pc_out, instr_valid stable; imem_req=0; no PC change.
REQ-034 branch_taken with target 32'h100 during S_REQ at addr 8, ack 3 cycles later -> data discarded, no valid; next imem_addr=32'h100.
REQ-035 branch_taken (target 32'h40) and instr_ready same cycle in S_VALID -> instruction dropped, fetch_count unchanged, next imem_addr=32'h40.
REQ-036 RESET_PC=32'hFFFF_FFFC, one transfer -> next imem_addr=0.
REQ-037 rst asserted while imem_req=1, ack during reset -> all outputs at reset values; first post-reset request to RESET_PC.
